// File: rtl/trace_pkg.sv
// Shared constants, FSM state type and record-to-frame helper for the commit tracer.
package trace_pkg;

    localparam int unsigned REC_W       = 100;
    localparam int unsigned FRAME_BYTES = 13;
    localparam int unsigned FRAME_W     = FRAME_BYTES * 8;

    localparam int unsigned HDR_SYNC = 7;
    localparam int unsigned HDR_RW   = 6;
    localparam int unsigned HDR_MW   = 5;
    localparam int unsigned HDR_OVF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Record holds only the upper header nibble; the low nibble is always zero on the wire.
    function automatic logic [FRAME_W-1:0] to_frame(input logic [REC_W-1:0] rec);
        return {rec[REC_W-1 -: 4], 4'b0000, rec[REC_W-5:0]};
    endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Byte-wide valid/ready trace stream.
interface trace_capture_if;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/trace_capture_fifo.sv
// Single-clock record FIFO; a push is accepted when full if a pop happens on the same edge.
module trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned REC_W = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [REC_W-1:0]         wdata,
    input  logic                     pop,
    output logic [REC_W-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [REC_W-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Commit tracer: qualifies RF writes / SRAM stores, packs 13-byte frames, streams them byte-wise.
module trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_en,
    input  logic [31:0]            pc,
    input  logic                   rf_we,
    input  logic [4:0]             rf_waddr,
    input  logic [31:0]            rf_wdata,
    input  logic [3:0]             data_sram_wen,
    input  logic [31:0]            data_sram_addr,
    input  logic [31:0]            data_sram_wdata,
    trace_capture_if.master        tx,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    logic               rw, mw, capture, accepted, drop, pop;
    logic [3:0]         flags;
    logic [31:0]        rec_addr, rec_data;
    logic [REC_W-1:0]   rec, head;
    logic               full, empty;

    logic               ovf_q, ovf_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [FRAME_W-1:0] sh_q, sh_d;

    always_comb begin
        rw       = rf_we && (rf_waddr != '0);
        mw       = |data_sram_wen;
        capture  = trace_en && (rw || mw);
        flags    = '0;
        flags[HDR_SYNC - 4] = 1'b1;
        flags[HDR_RW - 4]   = rw;
        flags[HDR_MW - 4]   = mw;
        flags[HDR_OVF - 4]  = ovf_q;
        rec_addr = mw ? data_sram_addr : {27'b0, rf_waddr};
        rec_data = rw ? rf_wdata : data_sram_wdata;
        rec      = {flags, pc, rec_addr, rec_data};
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .wdata (rec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Mirrors the FIFO's acceptance rule so drops and the sticky flag stay in lockstep with it.
    always_comb begin
        accepted = capture && (!full || pop);
        drop     = capture && full && !pop;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end else if (accepted) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = to_frame(head);
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!empty) begin
                            pop  = 1'b1;
                            sh_d = to_frame(head);
                        end else begin
                            sh_d    = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        sh_d  = {sh_q[FRAME_W-9:0], 8'h00};
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                sh_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sh_q    <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Shift register is zeroed whenever the FSM idles, so out_data reads 0 outside a frame.
    assign tx.out_valid = (state_q == SEND);
    assign tx.out_data  = sh_q[FRAME_W-1 -: 8];
    assign drop_cnt     = drop_q;

endmodule
